datapath_seq: RTL and testbench

- Control sequencer that sits directly upstream of the lab datapath, replacing manual switch-driven control.
- It accepts one command descriptor per start pulse, then steps the datapath through register read, execute and writeback cycles.
- It drives every datapath control input plus datapath_in, and signals completion.
- A board wrapper or testbench issues commands; the datapath consumes the outputs.

---
 rtl/datapath_seq.sv | 170 +++++++++++++++++
 tb/tb_datapath_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/datapath_seq.sv
// Control sequencer for the lab datapath: captures one command per start pulse
// and steps the datapath through register read, execute and writeback cycles.
module datapath_seq #(
  parameter int IMM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       cmd,
  input  logic [2:0]       rd,
  input  logic [2:0]       rn,
  input  logic [2:0]       rm,
  input  logic [1:0]       sh,
  input  logic [1:0]       aluop,
  input  logic [IMM_W-1:0] imm,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic             write,
  output logic             vsel,
  output logic             loada,
  output logic             loadb,
  output logic             asel,
  output logic             bsel,
  output logic             loadc,
  output logic             loads,
  output logic [1:0]       shift,
  output logic [1:0]       ALUop,
  output logic [15:0]      datapath_in,
  output logic             ready,
  output logic             done
);

  localparam logic [1:0] CMD_MOVI = 2'b00;
  localparam logic [1:0] CMD_ALU  = 2'b01;
  localparam logic [1:0] CMD_CMP  = 2'b10;
  localparam logic [1:0] CMD_MOVR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WIMM = 3'd1,
    S_GETA = 3'd2,
    S_GETB = 3'd3,
    S_EXEC = 3'd4,
    S_WRB  = 3'd5
  } state_t;

  state_t           state_r;
  state_t           state_n;
  logic             done_r;
  logic [1:0]       cmd_r;
  logic [2:0]       rd_r;
  logic [2:0]       rn_r;
  logic [2:0]       rm_r;
  logic [1:0]       sh_r;
  logic [1:0]       aluop_r;
  logic [IMM_W-1:0] imm_r;
  logic             capture_s;

  assign capture_s = (state_r == S_IDLE) && start;

  // State register; done marks the first IDLE cycle after a command finishes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      done_r  <= (state_r != S_IDLE) && (state_n == S_IDLE);
    end
  end

  // Command descriptor latches, loaded only at a capture edge
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_r   <= 2'b00;
      rd_r    <= 3'd0;
      rn_r    <= 3'd0;
      rm_r    <= 3'd0;
      sh_r    <= 2'b00;
      aluop_r <= 2'b00;
      imm_r   <= {IMM_W{1'b0}};
    end else if (capture_s) begin
      cmd_r   <= cmd;
      rd_r    <= rd;
      rn_r    <= rn;
      rm_r    <= rm;
      sh_r    <= sh;
      aluop_r <= aluop;
      imm_r   <= imm;
    end
  end

  // Next-state decode
  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          case (cmd)
            CMD_MOVI: state_n = S_WIMM;
            CMD_MOVR: state_n = S_GETB;
            default:  state_n = S_GETA;
          endcase
        end else begin
          state_n = S_IDLE;
        end
      end
      S_WIMM:  state_n = S_IDLE;
      S_GETA:  state_n = S_GETB;
      S_GETB:  state_n = S_EXEC;
      S_EXEC:  state_n = (cmd_r == CMD_CMP) ? S_IDLE : S_WRB;
      S_WRB:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath control decode from state and latched fields
  always_comb begin
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    vsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    case (state_r)
      S_WIMM: begin
        write    = 1'b1;
        vsel     = 1'b1;
        writenum = rd_r;
      end
      S_GETA: begin
        loada   = 1'b1;
        readnum = rn_r;
      end
      S_GETB: begin
        loadb   = 1'b1;
        readnum = rm_r;
      end
      S_EXEC: begin
        loadc = 1'b1;
        shift = sh_r;
        asel  = (cmd_r == CMD_MOVR);
        loads = (cmd_r == CMD_ALU) || (cmd_r == CMD_CMP);
        case (cmd_r)
          CMD_ALU: ALUop = aluop_r;
          CMD_CMP: ALUop = 2'b01;
          default: ALUop = 2'b00;
        endcase
      end
      S_WRB: begin
        write    = 1'b1;
        writenum = rd_r;
      end
      default: begin
        write = 1'b0;
      end
    endcase
    datapath_in             = 16'h0000;
    datapath_in[IMM_W-1:0]  = imm_r;
    ready                   = (state_r == S_IDLE);
    done                    = done_r;
  end

endmodule

// File: tb/tb_datapath_seq.sv
// Scoreboard bench for datapath_seq with a small behavioural datapath attached
// so register-file results of each command can be checked as well.
module tb_datapath_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  cmd, sh, aluop;
  logic [2:0]  rd, rn, rm;
  logic [7:0]  imm;
  logic [2:0]  readnum, writenum;
  logic        write, vsel, loada, loadb, asel, bsel, loadc, loads;
  logic [1:0]  shift, ALUop;
  logic [15:0] datapath_in;
  logic        ready, done;

  always #5 clk = ~clk;

  datapath_seq #(.IMM_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd), .rd(rd), .rn(rn),
    .rm(rm), .sh(sh), .aluop(aluop), .imm(imm), .readnum(readnum),
    .writenum(writenum), .write(write), .vsel(vsel), .loada(loada),
    .loadb(loadb), .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads),
    .shift(shift), .ALUop(ALUop), .datapath_in(datapath_in),
    .ready(ready), .done(done)
  );

  int checks = 0;
  int passed = 0;
  logic [35:0] expq [$];
  logic [35:0] mon_exp;
  logic [35:0] act;
  logic [15:0] exp_din;
  logic        pend_done;

  assign act = {readnum, writenum, write, vsel, loada, loadb, asel, bsel,
                loadc, loads, shift, ALUop, datapath_in, ready, done};

  // ctl bits: write vsel loada loadb asel bsel loadc loads
  function automatic logic [35:0] ov(input logic [2:0] rnum, input logic [2:0] wnum,
                                     input logic [7:0] ctl, input logic [1:0] shf,
                                     input logic [1:0] op, input logic [15:0] din,
                                     input logic rdy, input logic dn);
    return {rnum, wnum, ctl, shf, op, din, rdy, dn};
  endfunction

  // Behavioural datapath driven by the sequencer outputs
  logic [15:0] regs [8];
  logic [15:0] ra, rb, rc, bsh, ain, bin, alu_o;
  logic        rz;

  always_comb begin
    case (shift)
      2'b01:   bsh = {rb[14:0], 1'b0};
      2'b10:   bsh = {1'b0, rb[15:1]};
      2'b11:   bsh = {rb[15], rb[15:1]};
      default: bsh = rb;
    endcase
    ain = asel ? 16'h0000 : ra;
    bin = bsel ? {11'h000, datapath_in[4:0]} : bsh;
    case (ALUop)
      2'b00:   alu_o = ain + bin;
      2'b01:   alu_o = ain - bin;
      2'b10:   alu_o = ain & bin;
      default: alu_o = ~bin;
    endcase
  end

  always @(posedge clk) begin
    if (write === 1'b1) regs[writenum] <= vsel ? datapath_in : rc;
    if (loada === 1'b1) ra <= regs[readnum];
    if (loadb === 1'b1) rb <= regs[readnum];
    if (loadc === 1'b1) rc <= alu_o;
    if (loads === 1'b1) rz <= (alu_o == 16'h0000);
  end

  // Monitor: compare every presented output vector against the scoreboard
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      mon_exp = expq.pop_front();
      checks++;
      if (act === mon_exp) passed++;
      else $display("FAIL outvec t=%0t got %h expected %h", $time, act, mon_exp);
    end
  end

  task automatic chk(input string name, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s got %h expected %h", name, a, e);
  endtask

  task automatic step(input logic [35:0] v, input logic st, input logic rst);
    @(posedge clk); #1;
    start = st;
    reset = rst;
    expq.push_back(v);
  endtask

  task automatic idle(input logic st);
    step(ov(3'd0, 3'd0, 8'b0000_0000, 2'b00, 2'b00, exp_din, 1'b1, pend_done), st, 1'b0);
    pend_done = 1'b0;
  endtask

  // Busy cycle; optional start pulse with scrambled fields that must be ignored
  task automatic busy(input logic [35:0] v, input logic st, input logic rst);
    step(v, st, rst);
    if (st) begin
      cmd = 2'b00;
      imm = 8'hFF;
      rd  = 3'd7;
    end
  endtask

  task automatic run_cmd(input logic [1:0] c, input logic [2:0] d, input logic [2:0] n,
                         input logic [2:0] m, input logic [1:0] s, input logic [1:0] op,
                         input logic [7:0] im, input logic busy_start, input logic rst_getb);
    idle(1'b1);
    cmd = c; rd = d; rn = n; rm = m; sh = s; aluop = op; imm = im;
    exp_din = {8'h00, im};
    if (c == 2'b00) begin
      busy(ov(3'd0, d, 8'b1100_0000, 2'b00, 2'b00, exp_din, 1'b0, 1'b0), busy_start, 1'b0);
    end else begin
      if (c != 2'b11)
        busy(ov(n, 3'd0, 8'b0010_0000, 2'b00, 2'b00, exp_din, 1'b0, 1'b0), busy_start, 1'b0);
      busy(ov(m, 3'd0, 8'b0001_0000, 2'b00, 2'b00, exp_din, 1'b0, 1'b0), busy_start, rst_getb);
      if (rst_getb) begin
        exp_din   = 16'h0000;
        pend_done = 1'b0;
        return;
      end
      case (c)
        2'b01:   busy(ov(3'd0, 3'd0, 8'b0000_0011, s, op, exp_din, 1'b0, 1'b0), busy_start, 1'b0);
        2'b10:   busy(ov(3'd0, 3'd0, 8'b0000_0011, s, 2'b01, exp_din, 1'b0, 1'b0), busy_start, 1'b0);
        default: busy(ov(3'd0, 3'd0, 8'b0000_1010, s, 2'b00, exp_din, 1'b0, 1'b0), busy_start, 1'b0);
      endcase
      if (c != 2'b10)
        busy(ov(3'd0, d, 8'b1000_0000, 2'b00, 2'b00, exp_din, 1'b0, 1'b0), busy_start, 1'b0);
    end
    pend_done = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
    ra = 16'h0000; rb = 16'h0000; rc = 16'h0000; rz = 1'b0;
    reset = 1'b1; start = 1'b0; cmd = 2'b00; rd = 3'd0; rn = 3'd0; rm = 3'd0;
    sh = 2'b00; aluop = 2'b00; imm = 8'h00; exp_din = 16'h0000; pend_done = 1'b0;

    step(ov(3'd0, 3'd0, 8'b0000_0000, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b0), 1'b0, 1'b1);
    step(ov(3'd0, 3'd0, 8'b0000_0000, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b0), 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b0);

    // MOVI R3=2A, then back-to-back MOVI R0=7, MOVI R1=3
    run_cmd(2'b00, 3'd3, 3'd0, 3'd0, 2'b00, 2'b00, 8'h2A, 1'b0, 1'b0);
    run_cmd(2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 8'h07, 1'b0, 1'b0);
    run_cmd(2'b00, 3'd1, 3'd0, 3'd0, 2'b00, 2'b00, 8'h03, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("movi_r3", regs[3], 16'h002A);
    chk("movi_r0", regs[0], 16'h0007);
    chk("movi_r1", regs[1], 16'h0003);

    // ALU R2 = R0 + (R1 << 1) = 13
    run_cmd(2'b01, 3'd2, 3'd0, 3'd1, 2'b01, 2'b00, 8'h11, 1'b0, 1'b0);
    idle(1'b0);
    chk("alu_r2", regs[2], 16'h000D);

    // CMP R1, R1: no write, Z set
    run_cmd(2'b10, 3'd4, 3'd1, 3'd1, 2'b00, 2'b11, 8'h22, 1'b0, 1'b0);
    idle(1'b0);
    chk("cmp_z", {15'h0000, rz}, 16'h0001);
    chk("cmp_r4", regs[4], 16'h0000);

    // MOVR R5 = R0 with start pulses during busy states
    run_cmd(2'b11, 3'd5, 3'd6, 3'd0, 2'b00, 2'b01, 8'h33, 1'b1, 1'b0);
    idle(1'b0);
    chk("movr_r5", regs[5], 16'h0007);

    // ALU into R3 aborted by reset during GETB
    run_cmd(2'b01, 3'd3, 3'd0, 3'd1, 2'b00, 2'b00, 8'h44, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("abort_r3", regs[3], 16'h002A);

    @(negedge clk); #1;
    chk("queue_drained", 16'(expq.size()), 16'h0000);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
